// File: rtl/l1_cache_pkg.sv
// Shared types for the split-L1 tag/state controllers: request and L2 opcodes,
// MESI line states and the controller FSM states.
package l1_cache_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_EVICT = 2'd2,
    OP_CLEAR = 2'd3
  } req_op_e;

  typedef enum logic [1:0] {
    L2_READ      = 2'd0,
    L2_WRITEBACK = 2'd1,
    L2_UPGRADE   = 2'd2
  } l2_op_e;

  typedef enum logic [1:0] {
    MESI_I = 2'b00,
    MESI_M = 2'b01,
    MESI_E = 2'b10,
    MESI_S = 2'b11
  } mesi_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WB,
    ST_FILL,
    ST_UPG,
    ST_RESP,
    ST_CLR
  } state_e;

endpackage

// File: rtl/lru_age_update.sv
// True-LRU age update for one set: the touched way becomes age 0 and every way
// younger than it ages by one, so the ages stay a permutation of 0..WAYS-1.
module lru_age_update #(
  parameter  int unsigned WAYS  = 4,
  localparam int unsigned AGE_W = $clog2(WAYS)
) (
  input  logic [AGE_W-1:0] ages      [WAYS],
  input  logic [AGE_W-1:0] way,
  output logic [AGE_W-1:0] next_ages [WAYS]
);

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      next_ages[w] = ages[w];
      if (AGE_W'(w) == way) begin
        next_ages[w] = '0;
      end else if (ages[w] < ages[way]) begin
        next_ages[w] = ages[w] + AGE_W'(1);
      end
    end
  end

endmodule

// File: rtl/l1_cache_ctrl.sv
// Set-associative L1 tag/MESI/LRU controller between the CPU request port and L2.
// Holds no data; issues L2 read, write-back and upgrade transactions and keeps hit/miss counts.
module l1_cache_ctrl
  import l1_cache_pkg::*;
#(
  parameter  int unsigned WAYS     = 4,
  parameter  int unsigned SETS     = 64,
  parameter  int unsigned ADDR_W   = 32,
  parameter  int unsigned OFFSET_W = 6,
  parameter  int unsigned CNT_W    = 32,
  localparam int unsigned AGE_W    = $clog2(WAYS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic [AGE_W-1:0]  rsp_way,
  output logic              l2_valid,
  input  logic              l2_ready,
  output logic [1:0]        l2_op,
  output logic [ADDR_W-1:0] l2_addr,
  input  logic              l2_shared,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int unsigned INDEX_W = $clog2(SETS);
  localparam int unsigned TAG_W   = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned LINE_W  = ADDR_W - OFFSET_W;
  localparam int unsigned CLR_W   = INDEX_W + 1;

  state_e             state;
  req_op_e            op_q;
  logic [LINE_W-1:0]  line_q;
  logic [AGE_W-1:0]   way_q;
  logic [CLR_W-1:0]   clr_idx;
  logic [TAG_W-1:0]   tag_q  [SETS][WAYS];
  mesi_e              mesi_q [SETS][WAYS];
  logic [AGE_W-1:0]   age_q  [SETS][WAYS];

  logic [INDEX_W-1:0] set_idx;
  logic [TAG_W-1:0]   req_tag;
  logic               hit;
  logic [AGE_W-1:0]   hit_way;
  logic [AGE_W-1:0]   victim;
  mesi_e              hit_state;
  logic               touch_en;
  logic [AGE_W-1:0]   touch_way;
  logic [AGE_W-1:0]   cur_ages  [WAYS];
  logic [AGE_W-1:0]   next_ages [WAYS];
  logic               unused_offset;

  assign set_idx       = line_q[INDEX_W-1:0];
  assign req_tag       = line_q[LINE_W-1:INDEX_W];
  assign unused_offset = ^req_addr[OFFSET_W-1:0];

  // Tag match plus victim choice: lowest invalid way wins over the oldest way.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    victim  = '0;
    for (int w = 0; w < WAYS; w++) begin
      cur_ages[w] = age_q[set_idx][w];
      if (mesi_q[set_idx][w] != MESI_I && tag_q[set_idx][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = AGE_W'(w);
      end
      if (age_q[set_idx][w] == AGE_W'(WAYS - 1)) victim = AGE_W'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (mesi_q[set_idx][w] == MESI_I) victim = AGE_W'(w);
    end
    hit_state = mesi_q[set_idx][hit_way];
  end

  always_comb begin
    touch_en  = 1'b0;
    touch_way = way_q;
    case (state)
      ST_LOOKUP: begin
        touch_way = hit_way;
        touch_en  = hit && (op_q == OP_READ || (op_q == OP_WRITE && hit_state != MESI_S));
      end
      ST_FILL, ST_UPG: touch_en = l2_ready;
      default:         touch_en = 1'b0;
    endcase
  end

  lru_age_update #(.WAYS(WAYS)) u_lru (
    .ages      (cur_ages),
    .way       (touch_way),
    .next_ages (next_ages)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      op_q      <= OP_READ;
      line_q    <= '0;
      way_q     <= '0;
      clr_idx   <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_way   <= '0;
      l2_valid  <= 1'b0;
      l2_op     <= L2_READ;
      l2_addr   <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w]  <= '0;
          mesi_q[s][w] <= MESI_I;
          age_q[s][w]  <= AGE_W'(w);
        end
      end
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q      <= req_op_e'(req_op);
            line_q    <= req_addr[ADDR_W-1:OFFSET_W];
            req_ready <= 1'b0;
            if (req_op_e'(req_op) == OP_CLEAR) begin
              state    <= ST_CLR;
              clr_idx  <= '0;
              hit_cnt  <= '0;
              miss_cnt <= '0;
            end else begin
              state <= ST_LOOKUP;
            end
          end
        end

        ST_LOOKUP: begin
          if (op_q == OP_READ || op_q == OP_WRITE) begin
            if (hit) begin
              if (hit_cnt != {CNT_W{1'b1}}) hit_cnt <= hit_cnt + CNT_W'(1);
            end else if (miss_cnt != {CNT_W{1'b1}}) begin
              miss_cnt <= miss_cnt + CNT_W'(1);
            end
          end
          way_q <= hit ? hit_way : victim;
          if (op_q == OP_EVICT) begin
            if (hit && hit_state == MESI_M) begin
              state    <= ST_WB;
              l2_valid <= 1'b1;
              l2_op    <= L2_WRITEBACK;
              l2_addr  <= {line_q, OFFSET_W'(0)};
            end else begin
              if (hit) mesi_q[set_idx][hit_way] <= MESI_I;
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_hit   <= hit;
              rsp_way   <= hit ? hit_way : '0;
            end
          end else if (hit && op_q == OP_WRITE && hit_state == MESI_S) begin
            state    <= ST_UPG;
            l2_valid <= 1'b1;
            l2_op    <= L2_UPGRADE;
            l2_addr  <= {line_q, OFFSET_W'(0)};
          end else if (hit) begin
            if (op_q == OP_WRITE) mesi_q[set_idx][hit_way] <= MESI_M;
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_hit   <= 1'b1;
            rsp_way   <= hit_way;
          end else begin
            l2_valid <= 1'b1;
            if (mesi_q[set_idx][victim] == MESI_M) begin
              state   <= ST_WB;
              l2_op   <= L2_WRITEBACK;
              l2_addr <= {tag_q[set_idx][victim], set_idx, OFFSET_W'(0)};
            end else begin
              state   <= ST_FILL;
              l2_op   <= L2_READ;
              l2_addr <= {line_q, OFFSET_W'(0)};
            end
          end
        end

        // The victim's data leaves first; an EVICT ends here, a miss chains into the fill.
        ST_WB: begin
          if (l2_ready) begin
            if (op_q == OP_EVICT) begin
              mesi_q[set_idx][way_q] <= MESI_I;
              l2_valid  <= 1'b0;
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_hit   <= 1'b1;
              rsp_way   <= way_q;
            end else begin
              state   <= ST_FILL;
              l2_op   <= L2_READ;
              l2_addr <= {line_q, OFFSET_W'(0)};
            end
          end
        end

        ST_FILL: begin
          if (l2_ready) begin
            tag_q[set_idx][way_q]  <= req_tag;
            mesi_q[set_idx][way_q] <= (op_q == OP_WRITE) ? MESI_M :
                                      (l2_shared ? MESI_S : MESI_E);
            l2_valid  <= 1'b0;
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_hit   <= 1'b0;
            rsp_way   <= way_q;
          end
        end

        ST_UPG: begin
          if (l2_ready) begin
            mesi_q[set_idx][way_q] <= MESI_M;
            l2_valid  <= 1'b0;
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_hit   <= 1'b1;
            rsp_way   <= way_q;
          end
        end

        ST_RESP: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end

        // Sweep one set per cycle, then one extra cycle before the response.
        ST_CLR: begin
          if (clr_idx == CLR_W'(SETS)) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_hit   <= 1'b0;
            rsp_way   <= '0;
          end else begin
            for (int w = 0; w < WAYS; w++) begin
              mesi_q[clr_idx[INDEX_W-1:0]][w] <= MESI_I;
              age_q[clr_idx[INDEX_W-1:0]][w]  <= AGE_W'(w);
            end
            clr_idx <= clr_idx + CLR_W'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase

      if (touch_en) begin
        for (int w = 0; w < WAYS; w++) age_q[set_idx][w] <= next_ages[w];
      end
    end
  end

endmodule

// File: tb/tb_l1_cache_ctrl.sv
// Scoreboard bench for l1_cache_ctrl (WAYS=4, SETS=64): expected responses and L2
// transactions are queued with each request and popped as the DUT produces them.
module tb_l1_cache_ctrl;
  import l1_cache_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [31:0] req_addr = 32'd0;
  logic        rsp_valid;
  logic        rsp_hit;
  logic [1:0]  rsp_way;
  logic        l2_valid;
  logic        l2_ready = 1'b1;
  logic [1:0]  l2_op;
  logic [31:0] l2_addr;
  logic        l2_shared = 1'b0;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  typedef struct {
    logic       hit;
    logic [1:0] way;
    bit         chk_way;
  } rsp_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
  } l2_t;

  rsp_t rsp_q[$];
  l2_t  l2_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;

  l1_cache_ctrl #(
    .WAYS(4), .SETS(64), .ADDR_W(32), .OFFSET_W(6), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way),
    .l2_valid(l2_valid), .l2_ready(l2_ready), .l2_op(l2_op), .l2_addr(l2_addr),
    .l2_shared(l2_shared), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic exp_l2(input logic [1:0] op, input logic [31:0] addr);
    l2_q.push_back('{op, addr});
  endtask

  // Pop the scoreboards whenever the DUT completes a response or an L2 handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (l2_valid && l2_ready) begin
        if (l2_q.size() == 0) begin
          check("l2_unexpected", 64'(l2_q.size()), 64'd1);
        end else begin
          l2_t e;
          e = l2_q.pop_front();
          check("l2_op", 64'(l2_op), 64'(e.op));
          check("l2_addr", 64'(l2_addr), 64'(e.addr));
        end
      end
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          check("rsp_unexpected", 64'(rsp_q.size()), 64'd1);
        end else begin
          rsp_t r;
          r = rsp_q.pop_front();
          check("rsp_hit", 64'(rsp_hit), 64'(r.hit));
          if (r.chk_way) check("rsp_way", 64'(rsp_way), 64'(r.way));
        end
      end
    end
  end

  task automatic do_req(input logic [1:0] op, input logic [31:0] addr, input logic hit,
                        input logic [1:0] way, input bit chk_way, input int exp_lat);
    int acc;
    bit got;
    rsp_q.push_back('{hit, way, chk_way});
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = req_ready;
    end
    if (!got) check("req_ready_timeout", 64'(got), 64'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    @(posedge clk);
    #1;
    acc       = cyc;
    req_valid = 1'b0;
    req_op    = 2'($urandom);
    req_addr  = $urandom;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1;
        if (exp_lat > 0) check("latency", 64'(cyc + 1 - acc), 64'(exp_lat));
      end
    end
    if (!got) check("rsp_timeout", 64'(got), 64'd1);
    #1;
  endtask

  initial begin
    bit seen;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_l2_valid", 64'(l2_valid), 64'd0);
    check("rst_l2_op", 64'(l2_op), 64'd0);
    check("rst_l2_addr", 64'(l2_addr), 64'd0);
    check("rst_hit_cnt", 64'(hit_cnt), 64'd0);
    check("rst_miss_cnt", 64'(miss_cnt), 64'd0);
    #1;

    // Cold miss fills E, then a 2-cycle hit.
    exp_l2(L2_READ, 32'h1040);
    do_req(OP_READ, 32'h0000_1040, 1'b0, 2'd0, 1'b1, 0);
    check("t1_miss_cnt", 64'(miss_cnt), 64'd1);
    do_req(OP_READ, 32'h0000_1040, 1'b1, 2'd0, 1'b1, 2);
    check("t1_hit_cnt", 64'(hit_cnt), 64'd1);

    // Five writes to index 1: the fifth evicts dirty way 0.
    do_req(OP_WRITE, 32'h1040, 1'b1, 2'd0, 1'b1, 2);
    exp_l2(L2_READ, 32'h2040);
    do_req(OP_WRITE, 32'h2040, 1'b0, 2'd1, 1'b1, 0);
    exp_l2(L2_READ, 32'h3040);
    do_req(OP_WRITE, 32'h3040, 1'b0, 2'd2, 1'b1, 0);
    exp_l2(L2_READ, 32'h4040);
    do_req(OP_WRITE, 32'h4040, 1'b0, 2'd3, 1'b1, 0);
    exp_l2(L2_WRITEBACK, 32'h1040);
    exp_l2(L2_READ, 32'h5040);
    do_req(OP_WRITE, 32'h5040, 1'b0, 2'd0, 1'b1, 0);
    check("t2_hit_cnt", 64'(hit_cnt), 64'd2);
    check("t2_miss_cnt", 64'(miss_cnt), 64'd5);

    // Shared fill (victim way 1 is dirty), then a write upgrade held off by L2.
    l2_shared = 1'b1;
    exp_l2(L2_WRITEBACK, 32'h2040);
    exp_l2(L2_READ, 32'h1040);
    do_req(OP_READ, 32'h1040, 1'b0, 2'd1, 1'b1, 0);
    l2_shared = 1'b0;
    l2_ready  = 1'b0;
    exp_l2(L2_UPGRADE, 32'h1040);
    fork
      do_req(OP_WRITE, 32'h1040, 1'b1, 2'd1, 1'b1, 0);
      begin
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
          @(negedge clk);
          seen = l2_valid;
        end
        if (!seen) check("upg_timeout", 64'(seen), 64'd1);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("upg_hold_valid", 64'(l2_valid), 64'd1);
          check("upg_hold_op", 64'(l2_op), 64'(L2_UPGRADE));
          check("upg_hold_addr", 64'(l2_addr), 64'h1040);
        end
        @(posedge clk);
        #1 l2_ready = 1'b1;
      end
    join
    check("t3_hit_cnt", 64'(hit_cnt), 64'd3);
    check("t3_miss_cnt", 64'(miss_cnt), 64'd6);

    // EVICT of a dirty line writes back; EVICT of an absent line is silent.
    exp_l2(L2_WRITEBACK, 32'h1040);
    do_req(OP_EVICT, 32'h1040, 1'b1, 2'd1, 1'b1, 0);
    do_req(OP_EVICT, 32'h9040, 1'b0, 2'd0, 1'b0, 0);
    check("t4_hit_cnt", 64'(hit_cnt), 64'd3);
    check("t4_miss_cnt", 64'(miss_cnt), 64'd6);
    exp_l2(L2_READ, 32'h1040);
    do_req(OP_READ, 32'h1040, 1'b0, 2'd1, 1'b1, 0);
    check("t4_miss_after_evict", 64'(miss_cnt), 64'd7);

    // Populate other sets, then CLEAR and confirm everything misses.
    exp_l2(L2_READ, 32'h0080);
    do_req(OP_READ, 32'h0080, 1'b0, 2'd0, 1'b1, 0);
    exp_l2(L2_READ, 32'h00C0);
    do_req(OP_READ, 32'h00C0, 1'b0, 2'd0, 1'b1, 0);
    do_req(OP_READ, 32'h0080, 1'b1, 2'd0, 1'b1, 2);
    check("t5_hit_cnt", 64'(hit_cnt), 64'd4);
    check("t5_miss_cnt", 64'(miss_cnt), 64'd9);
    do_req(OP_CLEAR, 32'h0, 1'b0, 2'd0, 1'b1, 66);
    check("clr_hit_cnt", 64'(hit_cnt), 64'd0);
    check("clr_miss_cnt", 64'(miss_cnt), 64'd0);
    exp_l2(L2_READ, 32'h0080);
    do_req(OP_READ, 32'h0080, 1'b0, 2'd0, 1'b1, 0);
    exp_l2(L2_READ, 32'h1040);
    do_req(OP_READ, 32'h1040, 1'b0, 2'd0, 1'b1, 0);
    check("t5_post_hit", 64'(hit_cnt), 64'd0);
    check("t5_post_miss", 64'(miss_cnt), 64'd2);

    // Reset while a fill is outstanding.
    l2_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = req_ready;
    end
    req_valid = 1'b1;
    req_op    = OP_READ;
    req_addr  = 32'h00C0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = l2_valid;
    end
    if (!seen) check("fill_timeout", 64'(seen), 64'd1);
    check("t6_fill_op", 64'(l2_op), 64'(L2_READ));
    check("t6_fill_addr", 64'(l2_addr), 64'h00C0);
    #2 rst = 1'b1;
    #1;
    check("t6_l2_valid_drop", 64'(l2_valid), 64'd0);
    check("t6_rsp_valid", 64'(rsp_valid), 64'd0);
    check("t6_miss_cnt_rst", 64'(miss_cnt), 64'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    l2_ready = 1'b1;
    @(negedge clk);
    check("t6_req_ready", 64'(req_ready), 64'd1);
    #1;
    exp_l2(L2_READ, 32'h0080);
    do_req(OP_READ, 32'h0080, 1'b0, 2'd0, 1'b1, 0);
    check("t6_miss_after_rst", 64'(miss_cnt), 64'd1);
    check("t6_hit_after_rst", 64'(hit_cnt), 64'd0);

    repeat (3) @(negedge clk);
    check("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
    check("l2_q_drained", 64'(l2_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
